// File: rtl/arcade_input_mapper.sv
// Arcade input front end: PS/2 keys + HPS joysticks -> registered per-player controls,
// rotation remap, opposing-direction cleanup, queued coin pulses. Autofire under ARCADE_INPUT_AUTOFIRE_EN.
module arcade_input_mapper #(
    parameter int          PLAYERS       = 2,
    parameter int          BUTTONS       = 1,
    parameter logic [15:0] COIN_PULSE    = 16'd40000,
    parameter bit          COIN_ON_START = 1'b1,
    parameter logic [23:0] AUTOFIRE_DIV  = 24'd2000000
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [10:0]        ps2_key,
    input  logic [15:0]        joystick_0,
    input  logic [15:0]        joystick_1,
    input  logic [1:0]         rotate,
    input  logic [BUTTONS-1:0] autofire,
    output logic [3:0]         p1_dir,
    output logic [3:0]         p2_dir,
    output logic [BUTTONS-1:0] p1_btn,
    output logic [BUTTONS-1:0] p2_btn,
    output logic [1:0]         start,
    output logic [1:0]         coin
);
    localparam int SB = 4 + BUTTONS;  // joystick start1 bit; start2 = SB+1, coin = SB+2

    typedef enum logic [1:0] {IDLE, HIGH, GAP} coin_state_t;

    logic       key_tog, primed, key_evt, pressed, ext;
    logic [7:0] code;
    logic [3:0] k1_dir, k2_dir, k1_btn, k2_btn;
    logic [3:0] k1_dir_n, k2_dir_n, k1_btn_n, k2_btn_n;
    logic [1:0] k_start, k_coin, k_start_n, k_coin_n;

    logic [3:0]         m1_dir, m2_dir;
    logic [BUTTONS-1:0] m1_btn, m2_btn, af_mask;
    logic [1:0]         start_m, req_raw, req_prev, req_edge;
    logic               unused_bits;

    assign pressed = ps2_key[9];
    assign ext     = ps2_key[8];
    assign code    = ps2_key[7:0];
    assign key_evt = primed & (ps2_key[10] ^ key_tog);

    always_comb begin
        k1_dir_n  = k1_dir;
        k2_dir_n  = k2_dir;
        k1_btn_n  = k1_btn;
        k2_btn_n  = k2_btn;
        k_start_n = k_start;
        k_coin_n  = k_coin;
        if (key_evt) begin
            // Arrow keys arrive with or without the extended prefix
            case (code)
                8'h75:   k1_dir_n[3] = pressed;
                8'h72:   k1_dir_n[2] = pressed;
                8'h6B:   k1_dir_n[1] = pressed;
                8'h74:   k1_dir_n[0] = pressed;
                default: ;
            endcase
            if (!ext) begin
                case (code)
                    8'h14, 8'h29: k1_btn_n[0]  = pressed;
                    8'h11:        k1_btn_n[1]  = pressed;
                    8'h12:        k1_btn_n[2]  = pressed;
                    8'h1A:        k1_btn_n[3]  = pressed;
                    8'h2D:        k2_dir_n[3]  = pressed;
                    8'h2B:        k2_dir_n[2]  = pressed;
                    8'h23:        k2_dir_n[1]  = pressed;
                    8'h34:        k2_dir_n[0]  = pressed;
                    8'h1C:        k2_btn_n[0]  = pressed;
                    8'h1B:        k2_btn_n[1]  = pressed;
                    8'h15:        k2_btn_n[2]  = pressed;
                    8'h1D:        k2_btn_n[3]  = pressed;
                    8'h16, 8'h05: k_start_n[0] = pressed;
                    8'h1E, 8'h06: k_start_n[1] = pressed;
                    8'h2E:        k_coin_n[0]  = pressed;
                    8'h36:        k_coin_n[1]  = pressed;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            key_tog <= 1'b0;
            primed  <= 1'b0;
            k1_dir  <= '0;
            k2_dir  <= '0;
            k1_btn  <= '0;
            k2_btn  <= '0;
            k_start <= '0;
            k_coin  <= '0;
        end else begin
            key_tog <= ps2_key[10];
            primed  <= 1'b1;
            k1_dir  <= k1_dir_n;
            k2_dir  <= k2_dir_n;
            k1_btn  <= k1_btn_n;
            k2_btn  <= k2_btn_n;
            k_start <= k_start_n;
            k_coin  <= k_coin_n;
        end
    end

    // Merge uses the post-event key state so keys and joysticks share one cycle of latency
    always_comb begin
        m1_dir = k1_dir_n | joystick_0[3:0];
        m1_btn = k1_btn_n[BUTTONS-1:0] | joystick_0[SB-1:4];
        m2_dir = k2_dir_n | joystick_1[3:0];
        m2_btn = k2_btn_n[BUTTONS-1:0] | joystick_1[SB-1:4];
        if (PLAYERS == 1) begin
            m1_dir = m1_dir | joystick_1[3:0];
            m1_btn = m1_btn | joystick_1[SB-1:4];
            m2_dir = '0;
            m2_btn = '0;
        end
        start_m = k_start_n | joystick_0[SB+1:SB] | joystick_1[SB+1:SB];
        req_raw = k_coin_n | {1'b0, joystick_0[SB+2] | joystick_1[SB+2]}
                | (start_m & {2{COIN_ON_START}});
    end

    assign unused_bits = ^{joystick_0[15:SB+3], joystick_1[15:SB+3], k1_btn_n, k2_btn_n};

    function automatic logic [3:0] rot_clean(input logic [3:0] d, input logic [1:0] rot);
        logic [3:0] r;
        case (rot)
            2'd1:    r = {d[1], d[0], d[2], d[3]};
            2'd2:    r = {d[0], d[1], d[3], d[2]};
            default: r = d;
        endcase
        if (r[3] & r[2]) r[3:2] = 2'b00;
        if (r[1] & r[0]) r[1:0] = 2'b00;
        return r;
    endfunction

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    logic [23:0] af_cnt;
    logic        af_phase;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            af_cnt   <= '0;
            af_phase <= 1'b1;
        end else if (af_cnt == AUTOFIRE_DIV - 24'd1) begin
            af_cnt   <= '0;
            af_phase <= ~af_phase;
        end else begin
            af_cnt <= af_cnt + 24'd1;
        end
    end
    assign af_mask = {BUTTONS{af_phase}} | ~autofire;
`else
    logic unused_af;
    assign unused_af = ^autofire;
    assign af_mask   = '1;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            p1_dir   <= '0;
            p2_dir   <= '0;
            p1_btn   <= '0;
            p2_btn   <= '0;
            start    <= '0;
            req_prev <= '0;
            req_edge <= '0;
        end else begin
            p1_dir   <= rot_clean(m1_dir, rotate);
            p2_dir   <= rot_clean(m2_dir, rotate);
            p1_btn   <= m1_btn & af_mask;
            p2_btn   <= m2_btn & af_mask;
            start    <= start_m;
            req_prev <= req_raw;
            req_edge <= req_raw & ~req_prev;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_coin
        coin_state_t state, state_n;
        logic [15:0] cnt, cnt_n;
        logic [1:0]  pend, pend_n, pend_add;
        logic        pulse;

        // A request is queued before the GAP-expiry decision so a same-cycle request is not lost
        assign pend_add = (req_edge[g] && pend != 2'd3) ? pend + 2'd1 : pend;

        always_comb begin
            state_n = state;
            cnt_n   = cnt;
            pend_n  = pend;
            case (state)
                IDLE: begin
                    if (req_edge[g]) begin
                        state_n = HIGH;
                        cnt_n   = COIN_PULSE - 16'd1;
                    end
                end
                HIGH: begin
                    pend_n = pend_add;
                    if (cnt == '0) begin
                        state_n = GAP;
                        cnt_n   = COIN_PULSE - 16'd1;
                    end else begin
                        cnt_n = cnt - 16'd1;
                    end
                end
                GAP: begin
                    pend_n = pend_add;
                    if (cnt != '0) begin
                        cnt_n = cnt - 16'd1;
                    end else if (pend_add != '0) begin
                        state_n = HIGH;
                        cnt_n   = COIN_PULSE - 16'd1;
                        pend_n  = pend_add - 2'd1;
                    end else begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                state <= IDLE;
                cnt   <= '0;
                pend  <= '0;
                pulse <= 1'b0;
            end else begin
                state <= state_n;
                cnt   <= cnt_n;
                pend  <= pend_n;
                pulse <= (state_n == HIGH);
            end
        end

        assign coin[g] = pulse;
    end
endmodule

// File: tb/tb_arcade_input_mapper.sv
// Randomised self-checking bench for arcade_input_mapper with a table/queue reference model.
module tb_arcade_input_mapper;
    localparam int B  = 2;
    localparam int P  = 4;
    localparam int NK = 23;
    localparam logic [7:0] KCODE [NK] = '{8'h75, 8'h72, 8'h6B, 8'h74,
                                          8'h14, 8'h29, 8'h11, 8'h12, 8'h1A,
                                          8'h34, 8'h23, 8'h2B, 8'h2D,
                                          8'h1C, 8'h1B, 8'h15, 8'h1D,
                                          8'h16, 8'h05, 8'h1E, 8'h06, 8'h2E, 8'h36};
    // model key index: 0..3 p1 {r,l,d,u}, 4..7 p1 btn, 8..11 p2 dir, 12..15 p2 btn, 16/17 start, 18/19 coin
    localparam int KTGT [NK] = '{3, 2, 1, 0, 4, 4, 5, 6, 7, 8, 9, 10, 11,
                                 12, 13, 14, 15, 16, 16, 17, 17, 18, 19};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [10:0]  ps2_key = 11'h400;
    logic [15:0]  joy0 = '0;
    logic [15:0]  joy1 = '0;
    logic [1:0]   rotate = '0;
    logic [B-1:0] autofire = '0;
    logic [3:0]   p1_dir, p2_dir;
    logic [B-1:0] p1_btn, p2_btn;
    logic [1:0]   start, coin;

    int          vectors = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        tog = 1'b1;
    logic [19:0] mk = '0;
    logic [1:0]  raw_prev = '0;
    int          q0[$];
    int          q1[$];

    arcade_input_mapper #(
        .PLAYERS(2), .BUTTONS(B), .COIN_PULSE(16'(P)), .COIN_ON_START(1'b1), .AUTOFIRE_DIV(24'd3)
    ) dut (
        .clk_sys(clk), .reset(rst), .ps2_key(ps2_key), .joystick_0(joy0), .joystick_1(joy1),
        .rotate(rotate), .autofire(autofire), .p1_dir(p1_dir), .p2_dir(p2_dir),
        .p1_btn(p1_btn), .p2_btn(p2_btn), .start(start), .coin(coin)
    );

    always #5 clk = ~clk;

    // Directions on a compass (0=up,1=right,2=down,3=left); rotation shifts positions.
    function automatic logic [3:0] model_dir(input logic [3:0] udlr, input logic [1:0] rot);
        logic c[4];
        logic n[4];
        int   sh;
        c[0] = udlr[3]; c[1] = udlr[0]; c[2] = udlr[2]; c[3] = udlr[1];
        sh = (rot == 2'd1) ? 3 : (rot == 2'd2) ? 1 : 0;
        for (int p = 0; p < 4; p++) n[p] = c[(p + sh) % 4];
        for (int p = 0; p < 2; p++)
            if (n[p] && n[p+2]) begin n[p] = 1'b0; n[p+2] = 1'b0; end
        return {n[0], n[2], n[3], n[1]};
    endfunction

    function automatic logic [1:0] model_start();
        return mk[17:16] | {joy0[7] | joy1[7], joy0[6] | joy1[6]};
    endfunction

    function automatic logic [1:0] model_req();
        logic [1:0] s;
        s = model_start();
        return {mk[19] | s[1], mk[18] | joy0[8] | joy1[8] | s[0]};
    endfunction

    function automatic logic model_coin(input int slot, input int t);
        logic hit = 1'b0;
        if (slot == 0) begin
            foreach (q0[i]) if (t >= q0[i] && t < q0[i] + P) hit = 1'b1;
        end else begin
            foreach (q1[i]) if (t >= q1[i] && t < q1[i] + P) hit = 1'b1;
        end
        return hit;
    endfunction

    // A request seen at sample r starts a pulse at r+1, or right after the previous pulse's gap.
    task automatic schedule(input int slot, input int r);
        int waiting = 0;
        int last = -1000;
        int s;
        if (slot == 0) begin
            foreach (q0[i]) if (q0[i] >= r + 1) waiting++;
            if (q0.size() > 0) last = q0[$];
        end else begin
            foreach (q1[i]) if (q1[i] >= r + 1) waiting++;
            if (q1.size() > 0) last = q1[$];
        end
        if (waiting < 3) begin
            s = (last + 2*P > r + 1) ? last + 2*P : r + 1;
            if (slot == 0) q0.push_back(s); else q1.push_back(s);
        end
    endtask

    task automatic tick();
        logic [1:0] cur;
        @(posedge clk);
        #1;
        cyc++;
        cur = model_req();
        for (int s = 0; s < 2; s++) if (cur[s] && !raw_prev[s]) schedule(s, cyc);
        raw_prev = cur;
    endtask

    task automatic send_key(input logic pr, input logic ex, input logic [7:0] cd);
        tog = ~tog;
        ps2_key = {tog, pr, ex, cd};
        for (int i = 0; i < NK; i++) if (KCODE[i] == cd && (i < 4 || !ex)) mk[KTGT[i]] = pr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mk = '0;
        raw_prev = '0;
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        ps2_key = 11'h400;
        tog = 1'b1;
        do_reset();
        repeat (3) tick();
        vectors++; if (p1_dir !== 4'b0) begin errors++; $display("FAIL reset_p1_dir: got %b want 0000", p1_dir); end
        vectors++; if (p2_dir !== 4'b0) begin errors++; $display("FAIL reset_p2_dir: got %b want 0000", p2_dir); end
        vectors++; if (p1_btn !== '0) begin errors++; $display("FAIL reset_p1_btn: got %b want 0", p1_btn); end
        vectors++; if (p2_btn !== '0) begin errors++; $display("FAIL reset_p2_btn: got %b want 0", p2_btn); end
        vectors++; if (start !== 2'b0) begin errors++; $display("FAIL reset_start: got %b want 00", start); end
        vectors++; if (coin !== 2'b0) begin errors++; $display("FAIL reset_coin: got %b want 00", coin); end
    endtask

    task automatic test_arrow_keys();
        send_key(1'b1, 1'b1, 8'h75); tick();
        vectors++; if (p1_dir !== 4'b1000) begin errors++; $display("FAIL arrow_press: got %b want 1000", p1_dir); end
        send_key(1'b0, 1'b1, 8'h75); tick();
        vectors++; if (p1_dir !== 4'b0000) begin errors++; $display("FAIL arrow_release: got %b want 0000", p1_dir); end
        send_key(1'b1, 1'b1, 8'h14); tick();
        vectors++; if (p1_btn !== 2'b00) begin errors++; $display("FAIL ext_ctrl_ignored: got %b want 00", p1_btn); end
        send_key(1'b1, 1'b0, 8'h2D); tick();
        vectors++; if (p2_dir !== 4'b1000) begin errors++; $display("FAIL p2_up_key: got %b want 1000", p2_dir); end
        send_key(1'b0, 1'b0, 8'h2D); tick();
    endtask

    task automatic test_rotation();
        rotate = 2'd1; joy0 = 16'h0008; tick();
        vectors++; if (p1_dir !== 4'b0001) begin errors++; $display("FAIL rot_cw_up: got %b want 0001", p1_dir); end
        joy0 = 16'h000C; tick();
        vectors++; if (p1_dir !== 4'b0000) begin errors++; $display("FAIL rot_cw_cleanup: got %b want 0000", p1_dir); end
        rotate = 2'd2; joy0 = 16'h0008; tick();
        vectors++; if (p1_dir !== 4'b0010) begin errors++; $display("FAIL rot_ccw_up: got %b want 0010", p1_dir); end
        rotate = 2'd3; tick();
        vectors++; if (p1_dir !== 4'b1000) begin errors++; $display("FAIL rot_3_none: got %b want 1000", p1_dir); end
        rotate = 2'd0; joy0 = 16'h0003; tick();
        vectors++; if (p1_dir !== 4'b0000) begin errors++; $display("FAIL lr_cleanup: got %b want 0000", p1_dir); end
        joy0 = '0; tick();
    endtask

    task automatic test_random_merge();
        logic [3:0] e1, e2;
        logic [7:0] cd;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(1, 0) == 1) begin
                cd = ($urandom_range(3, 0) == 0) ? 8'($urandom) : KCODE[$urandom_range(NK-1, 0)];
                send_key(1'($urandom_range(1, 0)), 1'($urandom_range(3, 0) == 0), cd);
            end
            if ($urandom_range(3, 0) == 0) joy0 = {7'b0, 1'($urandom_range(7, 0) == 0), 8'($urandom)};
            if ($urandom_range(3, 0) == 0) joy1 = {8'b0, 8'($urandom)};
            if ($urandom_range(7, 0) == 0) rotate = 2'($urandom);
            tick();
            e1 = model_dir(mk[3:0] | joy0[3:0], rotate);
            e2 = model_dir(mk[11:8] | joy1[3:0], rotate);
            vectors++; if (p1_dir !== e1) begin errors++; $display("FAIL rnd_p1_dir @%0d: got %b want %b", cyc, p1_dir, e1); end
            vectors++; if (p2_dir !== e2) begin errors++; $display("FAIL rnd_p2_dir @%0d: got %b want %b", cyc, p2_dir, e2); end
            vectors++; if (p1_btn !== (mk[5:4] | joy0[5:4])) begin errors++; $display("FAIL rnd_p1_btn @%0d: got %b want %b", cyc, p1_btn, mk[5:4] | joy0[5:4]); end
            vectors++; if (p2_btn !== (mk[13:12] | joy1[5:4])) begin errors++; $display("FAIL rnd_p2_btn @%0d: got %b want %b", cyc, p2_btn, mk[13:12] | joy1[5:4]); end
            vectors++; if (start !== model_start()) begin errors++; $display("FAIL rnd_start @%0d: got %b want %b", cyc, start, model_start()); end
            vectors++; if (coin !== {model_coin(1, cyc), model_coin(0, cyc)}) begin errors++; $display("FAIL rnd_coin @%0d: got %b want %b", cyc, coin, {model_coin(1, cyc), model_coin(0, cyc)}); end
        end
        joy0 = '0; joy1 = '0; rotate = '0;
    endtask

    task automatic test_coin_burst();
        int first_req, first_rise = -1, rises = 0, highs = 0;
        logic prev_c = 1'b0;
        do_reset();
        for (int n = 0; n < 46; n++) begin
            if (n < 6) send_key(1'(n % 2 == 0), 1'b0, 8'h2E);
            tick();
            if (n == 0) first_req = cyc;
            vectors++; if (coin[0] !== model_coin(0, cyc)) begin errors++; $display("FAIL burst_coin @%0d: got %b want %b", cyc, coin[0], model_coin(0, cyc)); end
            if (coin[0] && !prev_c) begin rises++; if (first_rise < 0) first_rise = cyc; end
            if (coin[0]) highs++;
            prev_c = coin[0];
        end
        vectors++; if (rises !== 3) begin errors++; $display("FAIL burst_pulses: got %0d want 3", rises); end
        vectors++; if (highs !== 3*P) begin errors++; $display("FAIL burst_high_cycles: got %0d want %0d", highs, 3*P); end
        vectors++; if (first_rise !== first_req + 1) begin errors++; $display("FAIL burst_latency: got %0d want %0d", first_rise, first_req + 1); end
    endtask

    task automatic test_coin_on_start();
        int n0;
        logic ec;
        do_reset();
        send_key(1'b1, 1'b0, 8'h1E); tick();
        n0 = cyc;
        vectors++; if (start !== 2'b10) begin errors++; $display("FAIL start2_key: got %b want 10", start); end
        for (int k = 1; k <= 12; k++) begin
            tick();
            ec = (k >= 1 && k <= P);
            vectors++; if (coin !== {ec, 1'b0}) begin errors++; $display("FAIL start2_coin @+%0d: got %b want %b", cyc - n0, coin, {ec, 1'b0}); end
        end
        send_key(1'b0, 1'b0, 8'h1E); tick();
    endtask

    task automatic test_reset_mid_pulse();
        int guard = 0;
        do_reset();
        for (int n = 0; n < 6; n++) begin send_key(1'(n % 2 == 0), 1'b0, 8'h2E); tick(); end
        while (coin[0] !== 1'b1 && guard < 20) begin tick(); guard++; end
        vectors++; if (coin[0] !== 1'b1) begin errors++; $display("FAIL midreset_prepulse: got %b want 1", coin[0]); end
        rst = 1'b1;
        #1;
        vectors++; if (coin !== 2'b00) begin errors++; $display("FAIL midreset_async: got %b want 00", coin); end
        do_reset();
        for (int n = 0; n < 30; n++) begin
            tick();
            vectors++; if (coin !== 2'b00) begin errors++; $display("FAIL midreset_discard @%0d: got %b want 00", cyc, coin); end
        end
    endtask

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    task automatic test_autofire();
        logic v[12];
        do_reset();
        autofire = 2'b01; joy0 = 16'h0010;
        for (int i = 0; i < 12; i++) begin tick(); v[i] = p1_btn[0]; end
        for (int i = 3; i < 12; i++) begin
            vectors++; if (v[i] !== ~v[i-3]) begin errors++; $display("FAIL autofire_toggle %0d: got %b want %b", i, v[i], ~v[i-3]); end
        end
        autofire = 2'b00; tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++; if (p1_btn[0] !== 1'b1) begin errors++; $display("FAIL autofire_off: got %b want 1", p1_btn[0]); end
        end
        joy0 = '0; tick();
    endtask
`endif

    initial begin
        test_reset();
        test_arrow_keys();
        test_rotation();
        test_random_merge();
        test_coin_burst();
        test_coin_on_start();
        test_reset_mid_pulse();
`ifdef ARCADE_INPUT_AUTOFIRE_EN
        test_autofire();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
